// File: rtl/data_mem_stage.sv
// Memory-access stage: byte-addressed data RAM behind a wait-state FSM.
// Feeds the MEM/WB boundary and back-pressures the ALU stage.
module data_mem_stage #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic                  ByteOp,
    input  logic [4:0]            RdIn,
    input  logic                  RegWriteIn,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] Result,
    output logic [4:0]            RdOut,
    output logic                  RegWriteOut
);

    localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0] CNT_INIT =
        (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state, state_nx;
    logic [3:0] cnt;
    logic accept, done, is_mem;

    logic [DATA_WIDTH-1:0] q_alu, q_wd;
    logic [4:0] q_rd;
    logic q_we, q_re, q_byte, q_rw;

    logic [DATA_WIDTH-1:0] cur_alu, cur_wd;
    logic [4:0] cur_rd;
    logic cur_we, cur_re, cur_byte, cur_rw;

    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-3:0] widx;
    logic [1:0] lane;
    logic [3:0] strb;
    logic wen, load;
    logic [DATA_WIDTH-1:0] wdata, rdata, res_nx;
    logic [7:0] rbyte;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign is_mem = MemWrite | MemRead;

    // A stalled op completes from its latched copy; otherwise straight from the inputs.
    always_comb begin
        if (state == WAIT) begin
            cur_alu  = q_alu;
            cur_wd   = q_wd;
            cur_rd   = q_rd;
            cur_we   = q_we;
            cur_re   = q_re;
            cur_byte = q_byte;
            cur_rw   = q_rw;
        end else begin
            cur_alu  = ALUResult;
            cur_wd   = WriteData;
            cur_rd   = RdIn;
            cur_we   = MemWrite;
            cur_re   = MemRead;
            cur_byte = ByteOp;
            cur_rw   = RegWriteIn;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        accept   = 1'b0;
        done     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid;
                if (in_valid) begin
                    if (is_mem && WAIT_CYCLES > 0) state_nx = WAIT;
                    else                           done = 1'b1;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    done     = 1'b1;
                    state_nx = IDLE;
                end
            end
        endcase
    end

    assign addr  = cur_alu[ADDR_WIDTH-1:0];
    assign widx  = addr[ADDR_WIDTH-1:2];
    assign lane  = addr[1:0];
    assign strb  = cur_byte ? (4'b0001 << lane) : 4'b1111;
    assign wdata = cur_byte ? {4{cur_wd[7:0]}} : cur_wd;
    assign wen   = done & cur_we & ~rst;
    assign load  = cur_re & ~cur_we;
    assign rdata = mem[widx];
    assign rbyte = rdata[{lane, 3'b000} +: 8];

    always_comb begin
        res_nx = cur_alu;
        if (load) begin
            if (cur_byte) res_nx = {{(DATA_WIDTH-8){1'b0}}, rbyte};
            else          res_nx = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (wen) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= 4'd0;
            out_valid   <= 1'b0;
            Result      <= '0;
            RdOut       <= 5'd0;
            RegWriteOut <= 1'b0;
            q_alu       <= '0;
            q_wd        <= '0;
            q_rd        <= 5'd0;
            q_we        <= 1'b0;
            q_re        <= 1'b0;
            q_byte      <= 1'b0;
            q_rw        <= 1'b0;
        end else begin
            out_valid <= done;
            if (accept) begin
                q_alu  <= ALUResult;
                q_wd   <= WriteData;
                q_rd   <= RdIn;
                q_we   <= MemWrite;
                q_re   <= MemRead;
                q_byte <= ByteOp;
                q_rw   <= RegWriteIn;
                if (is_mem) cnt <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (done) begin
                Result      <= res_nx;
                RdOut       <= cur_rd;
                RegWriteOut <= cur_rw;
            end else begin
                RegWriteOut <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_stage.sv
// Scoreboard bench for data_mem_stage: one-wait-state and
// three-wait-state instances share the operand bus.
module tb_data_mem_stage;

    logic clk = 1'b0;
    logic rst_a, rst_b, valid_a, valid_b;
    logic [31:0] alu, wd;
    logic mw, mr, bo, rwi;
    logic [4:0] rdi;

    logic rdy_a, ov_a, rwo_a, rdy_b, ov_b, rwo_b;
    logic [31:0] res_a, res_b;
    logic [4:0] rdo_a, rdo_b;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        int          cyc;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    data_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst_a), .in_valid(valid_a), .in_ready(rdy_a),
        .ALUResult(alu), .WriteData(wd), .MemWrite(mw), .MemRead(mr),
        .ByteOp(bo), .RdIn(rdi), .RegWriteIn(rwi), .out_valid(ov_a),
        .Result(res_a), .RdOut(rdo_a), .RegWriteOut(rwo_a)
    );

    data_mem_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst_b), .in_valid(valid_b), .in_ready(rdy_b),
        .ALUResult(alu), .WriteData(wd), .MemWrite(mw), .MemRead(mr),
        .ByteOp(bo), .RdIn(rdi), .RegWriteIn(rwi), .out_valid(ov_b),
        .Result(res_b), .RdOut(rdo_b), .RegWriteOut(rwo_b)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_a) begin
            if (ov_a) begin
                if (qa.size() == 0) begin
                    check("a_spurious", {31'b0, ov_a}, 32'd0);
                end else begin
                    e = qa.pop_front();
                    check("a_res", res_a, e.res);
                    check("a_rd", {27'b0, rdo_a}, {27'b0, e.rd});
                    check("a_rw", {31'b0, rwo_a}, {31'b0, e.rw});
                    check("a_cyc", cyc, e.cyc);
                end
            end else begin
                check("a_rwgate", {31'b0, rwo_a}, 32'd0);
            end
        end
        if (!rst_b) begin
            if (ov_b) begin
                if (qb.size() == 0) begin
                    check("b_spurious", {31'b0, ov_b}, 32'd0);
                end else begin
                    e = qb.pop_front();
                    check("b_res", res_b, e.res);
                    check("b_rd", {27'b0, rdo_b}, {27'b0, e.rd});
                    check("b_rw", {31'b0, rwo_b}, {31'b0, e.rw});
                    check("b_cyc", cyc, e.cyc);
                end
            end else begin
                check("b_rwgate", {31'b0, rwo_b}, 32'd0);
            end
        end
        cyc++;
    end

    task automatic issue(input bit b, input logic [31:0] a, input logic [31:0] d,
                         input logic w, input logic r, input logic by,
                         input logic [4:0] rd, input logic rw,
                         input logic [31:0] exp, input bit push);
        exp_t e;
        int n;
        int acc;
        @(negedge clk);
        alu = a; wd = d; mw = w; mr = r; bo = by; rdi = rd; rwi = rw;
        if (b) valid_b = 1'b1;
        else   valid_a = 1'b1;
        n = 0;
        while (!(b ? rdy_b : rdy_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("rdy_timeout", 32'(n), 32'd0);
            valid_a = 1'b0;
            valid_b = 1'b0;
            return;
        end
        @(posedge clk);
        acc = cyc;
        #1;
        valid_a = 1'b0;
        valid_b = 1'b0;
        if (push) begin
            e.res = exp;
            e.rd  = rd;
            e.rw  = rw;
            e.cyc = acc + ((w | r) ? (b ? 3 : 1) : 0);
            if (b) qb.push_back(e);
            else   qa.push_back(e);
        end
        if (w | r) begin
            @(negedge clk);
            check(b ? "b_stall" : "a_stall", {31'b0, b ? rdy_b : rdy_a}, 32'd0);
        end
    endtask

    task automatic rst_chk(input bit b);
        check("rst_rdy", {31'b0, b ? rdy_b : rdy_a}, 32'd1);
        check("rst_ov", {31'b0, b ? ov_b : ov_a}, 32'd0);
        check("rst_res", b ? res_b : res_a, 32'd0);
        check("rst_rd", {27'b0, b ? rdo_b : rdo_a}, 32'd0);
        check("rst_rw", {31'b0, b ? rwo_b : rwo_a}, 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(qa.size() + qb.size()), 32'd0);
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        alu = '0; wd = '0; mw = 0; mr = 0; bo = 0; rwi = 0; rdi = '0;
        repeat (2) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        rst_chk(0);
        rst_chk(1);

        issue(0, 32'h0000_1234, 32'h0, 0, 0, 0, 5'd5, 1, 32'h0000_1234, 1);
        issue(0, 32'hFFFF_0001, 32'h0, 0, 0, 0, 5'd7, 0, 32'hFFFF_0001, 1);
        issue(0, 32'h0000_0010, 32'hDEAD_BEEF, 1, 0, 0, 5'd0, 0, 32'h0000_0010, 1);
        issue(0, 32'h0000_0010, 32'h0, 0, 1, 0, 5'd3, 1, 32'hDEAD_BEEF, 1);
        issue(0, 32'h0000_0013, 32'h0000_00A5, 1, 0, 1, 5'd0, 0, 32'h0000_0013, 1);
        issue(0, 32'h0000_0010, 32'h0, 0, 1, 0, 5'd4, 1, 32'hA5AD_BEEF, 1);
        issue(0, 32'h0000_0012, 32'h0, 0, 1, 1, 5'd6, 1, 32'h0000_00AD, 1);
        issue(0, 32'h0000_0013, 32'h0, 0, 1, 1, 5'd8, 1, 32'h0000_00A5, 1);
        issue(0, 32'h0000_1010, 32'h0102_0304, 1, 0, 0, 5'd0, 0, 32'h0000_1010, 1);
        issue(0, 32'h0000_0010, 32'h0, 0, 1, 0, 5'd9, 1, 32'h0102_0304, 1);
        issue(0, 32'h0000_0012, 32'h0, 0, 1, 0, 5'd10, 1, 32'h0102_0304, 1);
        issue(0, 32'h0000_0020, 32'h5566_7788, 1, 1, 0, 5'd11, 1, 32'h0000_0020, 1);
        issue(0, 32'h0000_0020, 32'h0, 0, 1, 0, 5'd12, 1, 32'h5566_7788, 1);
        drain();

        issue(1, 32'h0000_0020, 32'hCAFE_F00D, 1, 0, 0, 5'd1, 0, 32'h0000_0020, 1);
        issue(1, 32'h0000_0020, 32'h1122_3344, 1, 0, 0, 5'd2, 0, 32'h0, 0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        rst_chk(1);
        issue(1, 32'h0000_0020, 32'h0, 0, 1, 0, 5'd13, 1, 32'hCAFE_F00D, 1);
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
